regbank_write_arbiter: RTL and testbench
========================================

Name: regbank_write_arbiter

Overview:
- Owns the single write port of the 16 x 16-bit register bank (ALUBus data plus one-hot regEnable).
- Shares that port between NUM_REQ requesters, for example ALU writeback, memory load and debug/host poke.
- Runs a hardware clear sequence that walks r0..r15 to CLEAR_VALUE after reset or on command.
- Outputs connect directly to the register bank's ALUBus and regEnable inputs.

Parameters:
- DATA_W, 16: register and ALUBus width.
- ADDR_W, 4: register index width. The bank has 2^ADDR_W = 16 registers.
- NUM_REQ, 3: number of write requesters.
- CLEAR_VALUE, 16'h0000: value written to every register during a clear sequence.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i set: requester i has a pending write.
- req_addr  in  NUM_REQ*ADDR_W  packed target indices; requester i occupies bits [i*4+3:i*4].
- req_data  in  NUM_REQ*DATA_W  packed write data; requester i occupies bits [i*16+15:i*16].
- req_ready  out  NUM_REQ  one-hot grant, combinational; a write transfers when valid&ready are both high at a clock edge.
- clear_start  in  1  single-cycle pulse that starts a clear sequence.
- ALUBus  out  DATA_W  registered write data to the register bank.
- regEnable  out  16  registered one-hot write enable; bit k selects r_k.
- busy  out  1  high while a clear sequence is running.

Behaviour:
- Reset values:
  - ALUBus = 0, regEnable = 0, req_ready = 0, busy = 1.
  - State = CLEAR with clr_idx = 0; round-robin pointer = NUM_REQ-1.
- FSM has two states, CLEAR and RUN.
- CLEAR state:
  - Each cycle, register ALUBus <= CLEAR_VALUE and regEnable <= 1<<clr_idx, then increment clr_idx.
  - When clr_idx = 15, go to RUN at the next edge.
  - A clear takes exactly 16 cycles of regEnable activity: r0 first, r15 last.
  - req_ready = 0 throughout; busy = 1.
- RUN state:
  - busy = 0.
  - req_ready is one-hot on the winning valid requester and 0 when no requester is valid.
  - Arbitration is fixed priority, requester 0 highest (see Optional Feature).
- Grant latency:
  - A handshake at edge N registers ALUBus <= granted data and regEnable <= 1<<granted addr.
  - These values are visible during cycle N+1, and the bank captures them at edge N+1.
  - Sustained throughput is 1 write per cycle.
- In any RUN cycle without a grant, regEnable <= 0 at the next edge; ALUBus holds its last value.
- Requesters may drop valid without a grant; no state is kept for ungranted requests.
- Address mapping: all 16 indices are legal. r0 is writable, with no hardwired zero.
- Two requesters targeting the same register: only the winner writes that cycle. The loser stays pending and writes in a later cycle, so the last grant wins.
- clear_start in RUN:
  - Enter CLEAR at the next edge with clr_idx = 0.
  - req_ready is forced to 0 in the clear_start cycle, so no grant can collide with the clear.
  - A grant from the previous edge still completes in the first CLEAR cycle; its regEnable is already registered.
- clear_start during CLEAR: restart with clr_idx = 0 at the next edge. The 16 clear cycles are counted from the restart.
- reset at any point, including mid-clear or mid-grant, returns to the reset values at the next edge.
- regEnable is never multi-hot. Assert regEnable onehot0 every cycle.

Optional Feature:
- Macro: ROUND_ROBIN_EN.
- Defined:
  - Rotating priority. The search starts at (last_granted+1) mod NUM_REQ.
  - last_granted updates only on a handshake; the reset value NUM_REQ-1 makes requester 0 first.
  - Entering CLEAR does not change the pointer.
- Undefined: fixed priority with requester 0 highest. Pointer logic is absent.

Test Plan:
- Reset, then hold reset low with no requests:
  - busy = 1 for 16 cycles.
  - regEnable steps through 16'h0001, 16'h0002, ... 16'h8000 with ALUBus = 0, then drops to 0.
  - busy = 0 afterwards.
- RUN, req0 valid with addr 5, data 16'hAAAA for one cycle:
  - req_ready = 3'b001 that cycle.
  - Next cycle: regEnable = 16'h0020, ALUBus = 16'hAAAA.
  - The cycle after: regEnable = 0.
- RUN, all three requesters valid for 3 cycles with addrs 1/2/3 and data 16'h0011/16'h0022/16'h0033:
  - Fixed priority: req0 wins all 3 cycles (16'h0002 repeated).
  - With ROUND_ROBIN_EN: grants go req0, req1, req2, giving regEnable 16'h0002, 16'h0004, 16'h0008 on consecutive cycles.
- RUN, req1 valid with addr 15, data 16'h0089, with clear_start in the same cycle:
  - req_ready = 0; no write to r15 from req1.
  - Next 16 cycles clear r0..r15; busy = 1.
  - req1 is then granted once CLEAR completes.
- clear_start pulsed while clr_idx = 7:
  - The sequence restarts at regEnable = 16'h0001.
  - busy stays 1 for 16 further cycles.
- reset asserted mid-stream while req2 is granted every cycle:
  - At the next edge: regEnable = 0, ALUBus = 0, busy = 1, state = CLEAR, clr_idx = 0.

Source files
------------

// File: rtl/regbank_write_arbiter.sv
// ---------------------------------------------------------------------------
// regbank_write_arbiter
//
// Owns the single write port of the 2^ADDR_W x DATA_W register bank. NUM_REQ
// requesters (ALU writeback, memory load, debug poke, ...) share the port.
// After reset, or on clear_start, a hardware clear walks r0..r15 and writes
// CLEAR_VALUE to each register, one per cycle.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   req_valid    [NUM_REQ]         per-requester pending write
//   req_addr     [NUM_REQ*ADDR_W]  packed target register indices
//   req_data     [NUM_REQ*DATA_W]  packed write data
//   req_ready    [NUM_REQ]         one-hot combinational grant
//   clear_start  one-cycle pulse that (re)starts a clear sequence
//   ALUBus       [DATA_W]          registered write data to the bank
//   regEnable    [2^ADDR_W]        registered one-hot write enable
//   busy         high while a clear sequence is running
//
// Build option:
//   ROUND_ROBIN_EN  defined   -> rotating priority, search starts after the
//                                last granted requester
//                   undefined -> fixed priority, requester 0 highest
// ---------------------------------------------------------------------------
module regbank_write_arbiter #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 4,
    parameter int                NUM_REQ     = 3,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        clear_start,
    output logic [DATA_W-1:0]           ALUBus,
    output logic [(1<<ADDR_W)-1:0]      regEnable,
    output logic                        busy
);

    localparam int                NUM_REGS = 1 << ADDR_W;
    localparam int                PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   clr_idx, clr_idx_next;
    logic [DATA_W-1:0]   bus_next;
    logic [NUM_REGS-1:0] en_next;

    logic                found;
    logic [PTR_W-1:0]    win_idx;
    logic                grant;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;

`ifdef ROUND_ROBIN_EN
    logic [PTR_W-1:0]    last_granted;
`endif

    // -----------------------------------------------------------------------
    // Arbiter: pick the first valid requester in priority order.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        found   = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef ROUND_ROBIN_EN
            // Rotating search starting one past the last winner.
            if (!found && req_valid[(int'(last_granted) + 1 + i) % NUM_REQ]) begin
                found   = 1'b1;
                win_idx = PTR_W'((int'(last_granted) + 1 + i) % NUM_REQ);
            end
`else
            if (!found && req_valid[i]) begin
                found   = 1'b1;
                win_idx = PTR_W'(i);
            end
`endif
        end
    end

    // No grant while clearing, and none in a clear_start cycle, so a
    // requester write can never land on top of the clear walk.
    assign grant     = found && (state == ST_RUN) && !clear_start && !reset;
    assign req_ready = grant ? (NUM_REQ'(1) << win_idx) : '0;
    assign win_addr  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    assign win_data  = req_data[int'(win_idx)*DATA_W +: DATA_W];
    assign busy      = (state == ST_CLEAR);

    // -----------------------------------------------------------------------
    // Next-state and next-output logic.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        bus_next     = ALUBus;     // bus holds its last value when idle
        en_next      = '0;

        unique case (state)
            ST_CLEAR: begin
                bus_next = CLEAR_VALUE;
                en_next  = NUM_REGS'(1) << clr_idx;
                if (clear_start) begin
                    // Restart: this cycle's write still goes out, the walk
                    // begins again from r0 on the next cycle.
                    clr_idx_next = '0;
                end else if (clr_idx == LAST_IDX) begin
                    state_next   = ST_RUN;
                    clr_idx_next = '0;
                end else begin
                    clr_idx_next = clr_idx + 1'b1;
                end
            end

            ST_RUN: begin
                if (grant) begin
                    bus_next = win_data;
                    en_next  = NUM_REGS'(1) << win_addr;
                end
                if (clear_start) begin
                    state_next   = ST_CLEAR;
                    clr_idx_next = '0;
                end
            end

            default: begin
                state_next   = ST_CLEAR;
                clr_idx_next = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state     <= ST_CLEAR;
            clr_idx   <= '0;
            ALUBus    <= '0;
            regEnable <= '0;
        end else begin
            state     <= state_next;
            clr_idx   <= clr_idx_next;
            ALUBus    <= bus_next;
            regEnable <= en_next;
        end
    end

`ifdef ROUND_ROBIN_EN
    // Pointer moves only on a handshake; entering CLEAR leaves it untouched.
    // Reset value NUM_REQ-1 makes requester 0 the first in line.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_granted <= PTR_W'(NUM_REQ - 1);
        end else if (grant) begin
            last_granted <= win_idx;
        end
    end
`endif

    // The bank must never see two write enables at once.
    a_regenable_onehot0: assert property (@(posedge clk) $onehot0(regEnable));

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regbank_write_arbiter
//
// Directed scenarios with literal expectations, followed by a randomized run
// compared cycle by cycle against a behavioural model of the write port.
// ---------------------------------------------------------------------------
module tb_regbank_write_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 4;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid;
    logic [11:0] req_addr;
    logic [47:0] req_data;
    logic [2:0]  req_ready;
    logic        clear_start;
    logic [15:0] ALUBus;
    logic [15:0] regEnable;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model of what the bank port should show.
    bit          m_clearing = 1'b1;
    int          m_clr      = 0;
    int          m_last     = NUM_REQ - 1;
    logic [15:0] m_en       = '0;
    logic [15:0] m_bus      = '0;

    regbank_write_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .NUM_REQ    (NUM_REQ),
        .CLEAR_VALUE(16'h0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .clear_start(clear_start),
        .ALUBus     (ALUBus),
        .regEnable  (regEnable),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- model ----------------
    function automatic int model_winner();
`ifdef ROUND_ROBIN_EN
        for (int k = 1; k <= NUM_REQ; k++)
            if (req_valid[(m_last + k) % NUM_REQ]) return (m_last + k) % NUM_REQ;
`else
        for (int c = 0; c < NUM_REQ; c++)
            if (req_valid[c]) return c;
`endif
        return -1;
    endfunction

    function automatic logic [2:0] model_ready();
        int w;
        if (reset || m_clearing || clear_start) return 3'b000;
        w = model_winner();
        if (w < 0) return 3'b000;
        return 3'(1 << w);
    endfunction

    task automatic drive(input logic [2:0] v, input logic [3:0] a0, input logic [3:0] a1,
                         input logic [3:0] a2, input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic cs, input logic rst);
        req_valid   = v;
        req_addr    = {a2, a1, a0};
        req_data    = {d2, d1, d0};
        clear_start = cs;
        reset       = rst;
        #1;
    endtask

    // Apply one clock edge to both the DUT and the model.
    task automatic advance();
        bit          n_clearing;
        int          n_clr, n_last, w;
        logic [15:0] n_en, n_bus;
        n_clearing = m_clearing; n_clr = m_clr; n_last = m_last; n_en = m_en; n_bus = m_bus;
        if (reset) begin
            n_clearing = 1'b1; n_clr = 0; n_last = NUM_REQ - 1; n_en = '0; n_bus = '0;
        end else if (m_clearing) begin
            n_en  = 16'(1 << m_clr);
            n_bus = 16'h0000;
            if (clear_start)     n_clr = 0;
            else if (m_clr == 15) begin n_clearing = 1'b0; n_clr = 0; end
            else                 n_clr = m_clr + 1;
        end else begin
            w = clear_start ? -1 : model_winner();
            if (w >= 0) begin
                n_en   = 16'(1 << req_addr[w*4 +: 4]);
                n_bus  = req_data[w*16 +: 16];
                n_last = w;
            end else begin
                n_en = '0;
            end
            if (clear_start) begin n_clearing = 1'b1; n_clr = 0; end
        end
        @(posedge clk);
        #1;
        m_clearing = n_clearing; m_clr = n_clr; m_last = n_last; m_en = n_en; m_bus = n_bus;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        advance();
        advance();
        drive(3'b111, 1, 2, 3, 16'h1, 16'h2, 16'h3, 1'b0, 1'b0);
        n_cmp++; if (regEnable !== 16'h0000) begin n_bad++; $display("FAIL reset_en: got %h want %h", regEnable, 16'h0000); end
        n_cmp++; if (ALUBus !== 16'h0000) begin n_bad++; $display("FAIL reset_bus: got %h want %h", ALUBus, 16'h0000); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", busy); end
        n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL reset_ready: got %b want 000", req_ready); end
        drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            advance();
            n_cmp++; if (regEnable !== 16'(1 << (k - 1))) begin n_bad++; $display("FAIL clear_walk_en[%0d]: got %h want %h", k - 1, regEnable, 16'(1 << (k - 1))); end
            n_cmp++; if (ALUBus !== 16'h0000) begin n_bad++; $display("FAIL clear_walk_bus[%0d]: got %h want 0000", k - 1, ALUBus); end
            n_cmp++; if (busy !== (k < 16)) begin n_bad++; $display("FAIL clear_walk_busy[%0d]: got %b want %b", k - 1, busy, (k < 16)); end
        end
        advance();
        n_cmp++; if (regEnable !== 16'h0000) begin n_bad++; $display("FAIL clear_done_en: got %h want 0000", regEnable); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clear_done_busy: got %b want 0", busy); end
    endtask

    task automatic test_all_three();
        logic [2:0]  er[3];
        logic [15:0] ee[3];
        logic [15:0] eb[3];
`ifdef ROUND_ROBIN_EN
        er = '{3'b001, 3'b010, 3'b100};
        ee = '{16'h0002, 16'h0004, 16'h0008};
        eb = '{16'h0011, 16'h0022, 16'h0033};
`else
        er = '{3'b001, 3'b001, 3'b001};
        ee = '{16'h0002, 16'h0002, 16'h0002};
        eb = '{16'h0011, 16'h0011, 16'h0011};
`endif
        drive(3'b111, 1, 2, 3, 16'h0011, 16'h0022, 16'h0033, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (req_ready !== er[k]) begin n_bad++; $display("FAIL all3_ready[%0d]: got %b want %b", k, req_ready, er[k]); end
            advance();
            n_cmp++; if (regEnable !== ee[k]) begin n_bad++; $display("FAIL all3_en[%0d]: got %h want %h", k, regEnable, ee[k]); end
            n_cmp++; if (ALUBus !== eb[k]) begin n_bad++; $display("FAIL all3_bus[%0d]: got %h want %h", k, ALUBus, eb[k]); end
        end
        drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        advance();
    endtask

    task automatic test_single_write();
        drive(3'b001, 5, 0, 0, 16'hAAAA, 0, 0, 1'b0, 1'b0);
        n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL single_ready: got %b want 001", req_ready); end
        advance();
        drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        n_cmp++; if (regEnable !== 16'h0020) begin n_bad++; $display("FAIL single_en: got %h want 0020", regEnable); end
        n_cmp++; if (ALUBus !== 16'hAAAA) begin n_bad++; $display("FAIL single_bus: got %h want AAAA", ALUBus); end
        n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL single_idle_ready: got %b want 000", req_ready); end
        advance();
        n_cmp++; if (regEnable !== 16'h0000) begin n_bad++; $display("FAIL single_after_en: got %h want 0000", regEnable); end
        n_cmp++; if (ALUBus !== 16'hAAAA) begin n_bad++; $display("FAIL single_hold_bus: got %h want AAAA", ALUBus); end
    endtask

    task automatic test_clear_collision();
        drive(3'b010, 0, 15, 0, 0, 16'h0089, 0, 1'b1, 1'b0);
        n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL coll_ready: got %b want 000", req_ready); end
        advance();
        drive(3'b010, 0, 15, 0, 0, 16'h0089, 0, 1'b0, 1'b0);
        n_cmp++; if (regEnable !== 16'h0000) begin n_bad++; $display("FAIL coll_no_write: got %h want 0000", regEnable); end
        for (int k = 0; k < 16; k++) begin
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL coll_busy[%0d]: got %b want 1", k, busy); end
            n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL coll_clr_ready[%0d]: got %b want 000", k, req_ready); end
            advance();
            n_cmp++; if (regEnable !== 16'(1 << k)) begin n_bad++; $display("FAIL coll_clr_en[%0d]: got %h want %h", k, regEnable, 16'(1 << k)); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL coll_run_busy: got %b want 0", busy); end
        n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL coll_late_ready: got %b want 010", req_ready); end
        advance();
        drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        n_cmp++; if (regEnable !== 16'h8000) begin n_bad++; $display("FAIL coll_late_en: got %h want 8000", regEnable); end
        n_cmp++; if (ALUBus !== 16'h0089) begin n_bad++; $display("FAIL coll_late_bus: got %h want 0089", ALUBus); end
        advance();
    endtask

    task automatic test_clear_restart();
        drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        advance();
        drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) advance();
        n_cmp++; if (regEnable !== 16'h0040) begin n_bad++; $display("FAIL restart_pre_en: got %h want 0040", regEnable); end
        drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        advance();
        drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy[%0d]: got %b want 1", k, busy); end
            advance();
            n_cmp++; if (regEnable !== 16'(1 << k)) begin n_bad++; $display("FAIL restart_en[%0d]: got %h want %h", k, regEnable, 16'(1 << k)); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL restart_done_busy: got %b want 0", busy); end
        advance();
        n_cmp++; if (regEnable !== 16'h0000) begin n_bad++; $display("FAIL restart_done_en: got %h want 0000", regEnable); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            drive(3'b100, 0, 0, 9, 0, 0, 16'(16'h1230 + k), 1'b0, 1'b0);
            n_cmp++; if (req_ready !== 3'b100) begin n_bad++; $display("FAIL rmid_ready[%0d]: got %b want 100", k, req_ready); end
            advance();
            n_cmp++; if (regEnable !== 16'h0200) begin n_bad++; $display("FAIL rmid_en[%0d]: got %h want 0200", k, regEnable); end
            n_cmp++; if (ALUBus !== 16'(16'h1230 + k)) begin n_bad++; $display("FAIL rmid_bus[%0d]: got %h want %h", k, ALUBus, 16'(16'h1230 + k)); end
        end
        drive(3'b100, 0, 0, 9, 0, 0, 16'h1233, 1'b0, 1'b1);
        n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL rmid_rst_ready: got %b want 000", req_ready); end
        advance();
        n_cmp++; if (regEnable !== 16'h0000) begin n_bad++; $display("FAIL rmid_rst_en: got %h want 0000", regEnable); end
        n_cmp++; if (ALUBus !== 16'h0000) begin n_bad++; $display("FAIL rmid_rst_bus: got %h want 0000", ALUBus); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_rst_busy: got %b want 1", busy); end
        drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        advance();
        n_cmp++; if (regEnable !== 16'h0001) begin n_bad++; $display("FAIL rmid_clr0_en: got %h want 0001", regEnable); end
        for (int k = 0; k < 20 && busy; k++) advance();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_clear_end: got busy %b want 0 within 20 cycles", busy); end
        advance();
    endtask

    task automatic test_random();
        logic [2:0] exp_ready;
        for (int n = 0; n < 400; n++) begin
            drive(3'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 199) == 0));
            exp_ready = model_ready();
            n_cmp++; if (req_ready !== exp_ready) begin n_bad++; $display("FAIL rand_ready[%0d]: got %b want %b", n, req_ready, exp_ready); end
            n_cmp++; if (busy !== m_clearing) begin n_bad++; $display("FAIL rand_busy[%0d]: got %b want %b", n, busy, m_clearing); end
            n_cmp++; if (regEnable !== m_en) begin n_bad++; $display("FAIL rand_en[%0d]: got %h want %h", n, regEnable, m_en); end
            n_cmp++; if (ALUBus !== m_bus) begin n_bad++; $display("FAIL rand_bus[%0d]: got %h want %h", n, ALUBus, m_bus); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_all_three();
        test_single_write();
        test_clear_collision();
        test_clear_restart();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
